// File: rtl/collision_checker_if.sv
// collision_checker_if: request, T-rex box, obstacle geometry and result bundle for the collision checker
interface collision_checker_if #(
   parameter int N = 7
);
   logic               check;
   logic               clear;
   logic signed [10:0] trex_x;
   logic [9:0]         trex_y;
   logic [9:0]         trex_w;
   logic [9:0]         trex_h;
   logic               obstacle_start  [N];
   logic signed [10:0] obstacle_x_pos  [N];
   logic [9:0]         obstacle_y_pos  [N];
   logic [9:0]         obstacle_width  [N];
   logic [9:0]         obstacle_height [N];
   logic               busy;
   logic               done;
   logic               crash;
   logic [2:0]         hit_index;

   modport master (
      output check, clear, trex_x, trex_y, trex_w, trex_h,
      output obstacle_start, obstacle_x_pos, obstacle_y_pos, obstacle_width, obstacle_height,
      input  busy, done, crash, hit_index
   );

   modport slave (
      input  check, clear, trex_x, trex_y, trex_w, trex_h,
      input  obstacle_start, obstacle_x_pos, obstacle_y_pos, obstacle_width, obstacle_height,
      output busy, done, crash, hit_index
   );
endinterface

// File: rtl/collision_checker.sv
// collision_checker: scans the obstacle array one entry per cycle against the T-rex box, sticky crash flag
module collision_checker #(
   parameter int MAX_OBSTACLES = 7,
   parameter int MARGIN        = 1
) (
   input logic                i_clk,
   input logic                i_rst_n,
   collision_checker_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   localparam logic [2:0]         LAST = 3'(MAX_OBSTACLES - 1);
   localparam logic signed [12:0] M1   = 13'(MARGIN);
   localparam logic signed [12:0] M2   = 13'(2 * MARGIN);
   localparam logic signed [12:0] Z    = 13'sd0;

   state_t             r_state, w_next;
   logic [2:0]         r_idx, r_pidx, r_hidx, w_sel;
   logic               r_pv, r_phit, r_plast, r_crash;
   logic               w_eval, w_hit, w_stop;
   logic signed [10:0] r_tx;
   logic [9:0]         r_ty, r_tw, r_th;
   logic signed [12:0] w_ax, w_ay, w_aw, w_ah, w_bx, w_by, w_bw, w_bh;

   // Entry compare; its result is registered, so a scan decision lags the index by one cycle
   assign w_eval = r_state == SCAN && r_idx <= LAST;
   assign w_sel  = w_eval ? r_idx : 3'd0;
   assign w_ax   = 13'(r_tx) + M1;
   assign w_ay   = signed'(13'(r_ty)) + M1;
   assign w_aw   = signed'(13'(r_tw)) - M2;
   assign w_ah   = signed'(13'(r_th)) - M2;
   assign w_bx   = 13'(bus.obstacle_x_pos[w_sel]) + M1;
   assign w_by   = signed'(13'(bus.obstacle_y_pos[w_sel])) + M1;
   assign w_bw   = signed'(13'(bus.obstacle_width[w_sel])) - M2;
   assign w_bh   = signed'(13'(bus.obstacle_height[w_sel])) - M2;
   assign w_hit  = w_eval && bus.obstacle_start[w_sel] &&
                   w_aw > Z && w_ah > Z && w_bw > Z && w_bh > Z &&
                   w_ax < w_bx + w_bw && w_bx < w_ax + w_aw &&
                   w_ay < w_by + w_bh && w_by < w_ay + w_ah;
   assign w_stop = r_pv && (r_phit || r_plast);

   assign bus.busy      = r_state != IDLE;
   assign bus.done      = r_state == DONE;
   assign bus.crash     = r_crash;
   assign bus.hit_index = r_hidx;

   // Next state: accept check in IDLE, leave SCAN on a registered hit or after the last entry
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = bus.check ? SCAN : IDLE;
         SCAN:    w_next = w_stop ? DONE : SCAN;
         default: w_next = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   // Box latch, scan index, compare pipeline and sticky crash/hit_index
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_idx   <= '0;
         r_pidx  <= '0;
         r_pv    <= 1'b0;
         r_phit  <= 1'b0;
         r_plast <= 1'b0;
         r_crash <= 1'b0;
         r_hidx  <= '0;
         r_tx    <= '0;
         r_ty    <= '0;
         r_tw    <= '0;
         r_th    <= '0;
      end else if (r_state == IDLE) begin
         if (bus.clear) begin
            r_crash <= 1'b0;
            r_hidx  <= '0;
         end
         if (bus.check) begin
            r_idx <= '0;
            r_pv  <= 1'b0;
            r_tx  <= bus.trex_x;
            r_ty  <= bus.trex_y;
            r_tw  <= bus.trex_w;
            r_th  <= bus.trex_h;
         end
      end else if (r_state == SCAN) begin
         r_pv    <= w_eval;
         r_phit  <= w_hit;
         r_pidx  <= r_idx;
         r_plast <= r_idx == LAST;
         if (w_eval) r_idx <= r_idx + 3'd1;
         if (r_pv && r_phit && !r_crash) begin
            r_crash <= 1'b1;
            r_hidx  <= r_pidx;
         end
      end
   end
endmodule
